// File: rtl/result_collector.sv
// result_collector: turns the diagonally skewed columns leaving the PE array into aligned result rows.
// Latency: row_valid rises one cycle after the last element of a row is written into its column buffer.
// Backpressure: with row_valid && !row_ready the row is held and nothing is popped; columns keep filling.
// Ports: clk/reset (sync, active-low), start, pe_valid/pe_out (per-column samples),
//        row_valid/row_ready/row_data/row_index (row handshake), busy, done, overflow (sticky drop flag).
module result_collector #(
   parameter int MATRIX_SIZE = 2,
   parameter int DATA_SIZE   = 32
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic [MATRIX_SIZE-1:0]           pe_valid,
   input  logic [MATRIX_SIZE*DATA_SIZE-1:0] pe_out,
   output logic                             row_valid,
   input  logic                             row_ready,
   output logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data,
   output logic [((MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1)-1:0] row_index,
   output logic                             busy,
   output logic                             done,
   output logic                             overflow
);

   localparam int PW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;
   localparam int CW = $clog2(MATRIX_SIZE + 1);
   localparam logic [CW-1:0] N_C      = CW'(MATRIX_SIZE);
   localparam logic [PW-1:0] PTR_LAST = PW'(MATRIX_SIZE - 1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_COLLECT = 2'd1;
   localparam logic [1:0] S_DONE    = 2'd2;

   logic [1:0]                       state_q, state_d;
   logic [DATA_SIZE-1:0]             mem_q [MATRIX_SIZE][MATRIX_SIZE];
   logic [DATA_SIZE-1:0]             mem_d [MATRIX_SIZE][MATRIX_SIZE];
   logic [PW-1:0]                    wr_ptr_q [MATRIX_SIZE], wr_ptr_d [MATRIX_SIZE];
   logic [PW-1:0]                    rd_ptr_q [MATRIX_SIZE], rd_ptr_d [MATRIX_SIZE];
   logic [CW-1:0]                    cnt_q [MATRIX_SIZE], cnt_d [MATRIX_SIZE];
   logic [CW-1:0]                    tot_q [MATRIX_SIZE], tot_d [MATRIX_SIZE];
   logic [CW-1:0]                    row_cnt_q, row_cnt_d;
   logic                             row_valid_q, row_valid_d;
   logic [MATRIX_SIZE*DATA_SIZE-1:0] row_data_q, row_data_d;
   logic [PW-1:0]                    row_index_q, row_index_d;
   logic                             overflow_q, overflow_d;

   logic all_avail, hs, fire, push;

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      tot_d       = tot_q;
      row_cnt_d   = row_cnt_q;
      row_valid_d = row_valid_q;
      row_data_d  = row_data_q;
      row_index_d = row_index_q;
      overflow_d  = overflow_q;
      push        = 1'b0;

      all_avail = 1'b1;
      for (int c = 0; c < MATRIX_SIZE; c++) begin
         if (cnt_q[c] == '0) all_avail = 1'b0;
      end
      hs   = row_valid_q && row_ready;
      fire = (state_q == S_COLLECT) && all_avail && (!row_valid_q || row_ready);

      if (state_q == S_COLLECT) begin
         if (fire) begin
            for (int c = 0; c < MATRIX_SIZE; c++) begin
               row_data_d[c*DATA_SIZE +: DATA_SIZE] = mem_q[c][rd_ptr_q[c]];
               rd_ptr_d[c] = (rd_ptr_q[c] == PTR_LAST) ? '0 : rd_ptr_q[c] + PW'(1);
            end
            row_valid_d = 1'b1;
            row_index_d = row_cnt_q[PW-1:0];
            row_cnt_d   = row_cnt_q + CW'(1);
         end else if (hs) begin
            row_valid_d = 1'b0;
         end

         for (int c = 0; c < MATRIX_SIZE; c++) begin
            push = 1'b0;
            if (pe_valid[c]) begin
               // A full column may still accept when the row fire frees a slot this cycle.
               if ((tot_q[c] < N_C) && ((cnt_q[c] < N_C) || fire)) begin
                  push = 1'b1;
                  mem_d[c][wr_ptr_q[c]] = pe_out[c*DATA_SIZE +: DATA_SIZE];
                  wr_ptr_d[c] = (wr_ptr_q[c] == PTR_LAST) ? '0 : wr_ptr_q[c] + PW'(1);
                  tot_d[c]    = tot_q[c] + CW'(1);
               end else begin
                  overflow_d = 1'b1;
               end
            end
            cnt_d[c] = cnt_q[c] + CW'(push) - CW'(fire);
         end

         // Last row accepted downstream: all columns are drained by construction.
         if (hs && (row_index_q == PTR_LAST)) begin
            state_d     = S_DONE;
            row_valid_d = 1'b0;
         end
      end else if (start) begin
         state_d     = S_COLLECT;
         row_cnt_d   = '0;
         row_valid_d = 1'b0;
         overflow_d  = 1'b0;
         for (int c = 0; c < MATRIX_SIZE; c++) begin
            wr_ptr_d[c] = '0;
            rd_ptr_d[c] = '0;
            cnt_d[c]    = '0;
            tot_d[c]    = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q     <= S_IDLE;
         row_cnt_q   <= '0;
         row_valid_q <= 1'b0;
         row_data_q  <= '0;
         row_index_q <= '0;
         overflow_q  <= 1'b0;
         for (int c = 0; c < MATRIX_SIZE; c++) begin
            wr_ptr_q[c] <= '0;
            rd_ptr_q[c] <= '0;
            cnt_q[c]    <= '0;
            tot_q[c]    <= '0;
         end
      end else begin
         state_q     <= state_d;
         row_cnt_q   <= row_cnt_d;
         row_valid_q <= row_valid_d;
         row_data_q  <= row_data_d;
         row_index_q <= row_index_d;
         overflow_q  <= overflow_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         tot_q       <= tot_d;
      end
   end

   // Buffer storage needs no reset: occupancy counts gate every read.
   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign row_valid = row_valid_q;
   assign row_data  = row_data_q;
   assign row_index = row_index_q;
   assign busy      = (state_q == S_COLLECT);
   assign done      = (state_q == S_DONE);
   assign overflow  = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Bench for result_collector: directed skew/backpressure/overflow/reset sequences, then random traffic.
// Every cycle the DUT outputs are compared against a queue-based reference model.
module tb_result_collector;

   localparam int N = 2;
   localparam int D = 32;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic           start = 1'b0;
   logic [N-1:0]   pe_valid = '0;
   logic [N*D-1:0] pe_out = '0;
   logic           row_valid;
   logic           row_ready = 1'b0;
   logic [N*D-1:0] row_data;
   logic           row_index;
   logic           busy, done, overflow;

   int total = 0;
   int bad = 0;

   result_collector #(.MATRIX_SIZE(N), .DATA_SIZE(D)) dut (
      .clk(clk), .reset(reset), .start(start), .pe_valid(pe_valid), .pe_out(pe_out),
      .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data), .row_index(row_index),
      .busy(busy), .done(done), .overflow(overflow)
   );

   always #5 clk = ~clk;

   // Reference model: 0 idle, 1 collecting, 2 done.
   int             m_mode = 0;
   logic [D-1:0]   m_q [N][$];
   int             m_tot [N];
   logic           m_rv = 1'b0;
   logic [N*D-1:0] m_rd = '0;
   int             m_ri = 0;
   int             m_rows = 0;
   logic           m_ovf = 1'b0;

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic check_model();
      check("row_valid", row_valid, m_rv);
      check("row_data", row_data, m_rd);
      check("row_index", row_index, m_ri);
      check("busy", busy, m_mode == 1);
      check("done", done, m_mode == 2);
      check("overflow", overflow, m_ovf);
   endtask

   task automatic clear_model();
      for (int c = 0; c < N; c++) begin
         m_q[c].delete();
         m_tot[c] = 0;
      end
      m_rows = 0;
      m_ovf  = 1'b0;
      m_rv   = 1'b0;
   endtask

   task automatic step_model();
      bit hs, fire, last;
      if (!reset) begin
         clear_model();
         m_mode = 0;
         m_rd   = '0;
         m_ri   = 0;
         return;
      end
      if (m_mode == 1) begin
         hs   = m_rv && row_ready;
         last = hs && (m_ri == N - 1);
         fire = !m_rv || row_ready;
         for (int c = 0; c < N; c++) if (m_q[c].size() == 0) fire = 0;
         if (fire) begin
            for (int c = 0; c < N; c++) m_rd[c*D +: D] = m_q[c].pop_front();
            m_rv = 1'b1;
            m_ri = m_rows;
            m_rows++;
         end else if (hs) begin
            m_rv = 1'b0;
         end
         // Pops already applied, so a freed slot is visible to this cycle's push.
         for (int c = 0; c < N; c++) begin
            if (pe_valid[c]) begin
               if (m_tot[c] < N && m_q[c].size() < N) begin
                  m_q[c].push_back(pe_out[c*D +: D]);
                  m_tot[c]++;
               end else begin
                  m_ovf = 1'b1;
               end
            end
         end
         if (last) begin
            m_mode = 2;
            m_rv   = 1'b0;
         end
      end else if (start) begin
         clear_model();
         m_mode = 1;
      end
   endtask

   // One clock: drive inputs, let the edge happen, advance model, compare on falling edge.
   task automatic cyc(input logic rs, input logic st, input logic [N-1:0] pv,
                      input logic [N*D-1:0] po, input logic rr);
      reset = rs; start = st; pe_valid = pv; pe_out = po; row_ready = rr;
      @(posedge clk);
      step_model();
      @(negedge clk);
      check_model();
   endtask

   function automatic logic [N*D-1:0] rnd_data();
      logic [N*D-1:0] v;
      for (int c = 0; c < N; c++) v[c*D +: D] = $urandom;
      return v;
   endfunction

   // Drives the skewed 2x2 fill: {col1,col0} = {-,10}, {11,20}, {21,-}.
   task automatic skew_fill(input logic rr);
      cyc(1, 0, 2'b01, {32'h0, 32'h10}, rr);
      cyc(1, 0, 2'b11, {32'h11, 32'h20}, rr);
      cyc(1, 0, 2'b10, {32'h21, 32'h0}, rr);
   endtask

   localparam logic [N*D-1:0] ROW0 = {32'h11, 32'h10};
   localparam logic [N*D-1:0] ROW1 = {32'h21, 32'h20};

   initial begin
      @(negedge clk);
      // Reset held with random activity on the inputs.
      for (int i = 0; i < 2; i++) begin
         cyc(0, 1'($urandom), 2'($urandom), rnd_data(), 1'($urandom));
         check("rst_valid", row_valid, 0);
         check("rst_data", row_data, 0);
      end
      for (int i = 0; i < 3; i++) cyc(1, 0, 2'($urandom), rnd_data(), 1);
      check("idle_ovf", overflow, 0);

      // Skewed fill, always ready.
      cyc(1, 1, 2'b00, '0, 1);
      skew_fill(1);
      check("skew_v0", row_valid, 1);
      check("skew_d0", row_data, ROW0);
      check("skew_i0", row_index, 0);
      cyc(1, 0, 2'b00, '0, 1);
      check("skew_d1", row_data, ROW1);
      check("skew_i1", row_index, 1);
      cyc(1, 0, 2'b00, '0, 1);
      check("skew_done", done, 1);
      check("skew_busy", busy, 0);
      cyc(1, 0, 2'b11, rnd_data(), 1);
      check("done_ignore", overflow, 0);

      // Restart from DONE, then backpressure until edge 8.
      cyc(1, 1, 2'b00, '0, 0);
      check("rs_done", done, 0);
      check("rs_busy", busy, 1);
      skew_fill(0);
      check("bp_d3", row_data, ROW0);
      for (int k = 4; k <= 8; k++) begin
         cyc(1, 0, 2'b00, '0, 0);
         check("bp_hold", row_data, ROW0);
         check("bp_ovf", overflow, 0);
      end
      cyc(1, 0, 2'b00, '0, 1);
      check("bp_d9", row_data, ROW1);
      cyc(1, 0, 2'b00, '0, 1);
      check("bp_done", done, 1);

      // Overflow: a third sample on column 0.
      cyc(1, 1, 2'b00, '0, 1);
      skew_fill(1);
      cyc(1, 0, 2'b01, {32'h0, 32'hFF}, 1);
      check("ovf_set", overflow, 1);
      check("ovf_row1", row_data, ROW1);
      cyc(1, 0, 2'b00, '0, 1);
      check("ovf_done", done, 1);
      cyc(1, 1, 2'b00, '0, 1);
      check("ovf_clear", overflow, 0);

      // Mid-operation reset.
      cyc(1, 0, 2'b01, {32'h0, 32'h10}, 1);
      cyc(0, 0, 2'b11, rnd_data(), 1);
      check("mid_busy", busy, 0);
      check("mid_data", row_data, 0);
      for (int i = 0; i < 4; i++) begin
         cyc(1, 0, 2'($urandom), rnd_data(), 1);
         check("mid_nvalid", row_valid, 0);
      end

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(63) != 0), ($urandom_range(11) == 0),
             (($urandom_range(3) == 0) ? 2'($urandom) : 2'b00),
             rnd_data(), ($urandom_range(3) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
- Output-side counterpart of the systolic-array scheduler: consumes the skewed per-column results leaving the bottom of the PE array and reassembles them into row-aligned result vectors.
- Column c's element of result row r arrives r+c cycles after the first valid sample (diagonal skew).
- Buffers each column independently, emits one full row per valid/ready handshake, and signals done after MATRIX_SIZE rows.
- Sits between the PE array outputs and the downstream result sink/memory writer.

Parameters:
- MATRIX_SIZE, 2, array dimension n: number of columns and number of result rows per operation.
- DATA_SIZE, 32, bit width of one result element.

Ports:
- clk  input  1  single clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0, sampled on rising clk).
- start  input  1  one-cycle pulse from the scheduler side; arms collection of one result matrix.
- pe_valid  input  MATRIX_SIZE  per-column sample strobe from the bottom PE row.
- pe_out  input  MATRIX_SIZE*DATA_SIZE  column c data at [c*DATA_SIZE +: DATA_SIZE].
- row_valid  output  1  row_data holds a complete row.
- row_ready  input  1  downstream accepts the row when row_valid && row_ready.
- row_data  output  MATRIX_SIZE*DATA_SIZE  assembled row; column c at [c*DATA_SIZE +: DATA_SIZE].
- row_index  output  clog2(MATRIX_SIZE) (min 1)  index of the row currently in row_data.
- busy  output  1  high in COLLECT.
- done  output  1  high in DONE, held until the next start or reset.
- overflow  output  1  sticky error: a column sample was dropped.

Behaviour:
- Reset (reset==0 at clk edge):
  - state=IDLE.
  - row_valid, row_data, row_index, busy, done, overflow all 0.
  - All column pointers, counts and per-column write totals cleared.
  - Reset overrides every other input, including mid-operation.
- States:
  - IDLE: pe_valid ignored (nothing stored, no overflow). start -> COLLECT; clears buffers, write totals, row counter and overflow.
  - COLLECT: busy=1. Accept samples and emit rows. When the handshake for row MATRIX_SIZE-1 completes -> DONE.
  - DONE: done=1, busy=0, row_valid=0. pe_valid ignored. start -> COLLECT with the same clearing as IDLE.
  - start while in COLLECT is ignored.
- Column buffers:
  - One FIFO per column, depth MATRIX_SIZE, with a wrap-around read/write pointer and an occupancy count.
  - In COLLECT, pe_valid[c] pushes pe_out column c, provided both hold: the column's write total < MATRIX_SIZE, and the FIFO is not full (or is being popped in the same cycle).
  - Otherwise the sample is dropped and overflow is set (sticky).
  - Simultaneous push and pop on one column leaves the count unchanged; push into a full FIFO with a same-cycle pop is legal.
- Row assembly:
  - fire = (every column count > 0) && (!row_valid || row_ready).
  - On fire: pop the head of every column and register it into row_data; row_valid=1; row_index = row counter; row counter increments.
  - Latency: row_valid rises the cycle after the last needed column element was written.
  - Back-to-back rows are possible: a handshake and a fire in the same cycle keep row_valid=1 with the new data.
  - With row_valid && !row_ready, row_data and row_index are held stable and no pop occurs.
  - Handshake without fire: row_valid falls the next cycle.
- No arithmetic on the data path: data is passed through unmodified. Counters are sized to hold MATRIX_SIZE without wrap.

Test Plan:
- Reset: hold reset=0 for 2 cycles with random pe_valid/start -> all outputs 0, state IDLE; release, no activity until start.
- Skewed fill (n=2), row_ready=1, samples given as {col1,col0} per cycle: start; c1 pe_valid=01 col0=0x10; c2 pe_valid=11 col0=0x20 col1=0x11; c3 pe_valid=10 col1=0x21.
  - c3: row_valid=1, row_data={0x11,0x10}, row_index=0.
  - c4: row_data={0x21,0x20}, row_index=1.
  - c5: done=1, busy=0.
- Backpressure: same stimulus with row_ready=0 until c8 -> row_data={0x11,0x10} stable c3..c8, overflow=0; row1 appears c9, done c10.
- Overflow: after the full stimulus, a third pe_valid=01 on col0 with 0xFF -> overflow=1 next cycle; emitted rows unchanged.
- Mid-operation reset: reset=0 at c2 -> c3 all outputs 0; later pe_valid without start -> no row_valid, no overflow.
- Restart/idle-ignore: pe_valid in IDLE and in DONE is ignored; start in DONE -> done=0, busy=1, overflow cleared, second matrix collected correctly.
